// File: rtl/game_ctrl.sv
// Falling-bar game controller: bar/hole/player state machine, LFSR hole placement,
// collision detection, lives, scoring and level speed-up. All outputs registered.
module game_ctrl #(
  parameter int unsigned STEP       = 8,
  parameter int unsigned PLR_TOP    = 440,
  parameter int unsigned BAR_EXIT   = 509,
  parameter int unsigned HIT_FRAMES = 30,
  parameter int unsigned LEVEL_BARS = 8
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [8:0] barpos,
  output logic [3:0] holepos,
  output logic [3:0] plrpos,
  output logic [1:0] lives,
  output logic [2:0] cyclesneeded,
  output logic [7:0] score,
  output logic       hit,
  output logic       game_over
);

  localparam int unsigned HW = $clog2(HIT_FRAMES + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [2:0]    r_fcnt;
  logic [HW-1:0] r_hcnt;

  logic       w_fb;
  logic [3:0] w_newhole;
  logic [9:0] w_sum;
  logic       w_wrap;
  logic       w_cross;
  logic       w_miss;
  logic       w_step;
  logic [7:0] w_score_inc;
  logic       w_levelup;
  logic [1:0] w_lives_dec;
  logic       w_mv_l;
  logic       w_mv_r;

  // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign w_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_newhole = (r_lfsr[3:0] == 4'd14) ? 4'd0 :
                     (r_lfsr[3:0] == 4'd15) ? 4'd1 : r_lfsr[3:0];

  assign w_sum       = {1'b0, barpos} + 10'(STEP);
  assign w_wrap      = w_sum >= 10'(BAR_EXIT);
  assign w_cross     = ({1'b0, barpos} < 10'(PLR_TOP)) && (w_sum >= 10'(PLR_TOP));
  assign w_miss      = (plrpos < holepos) || ({1'b0, plrpos} > ({1'b0, holepos} + 5'd2));
  assign w_step      = frame_tick && (r_fcnt == (cyclesneeded - 3'd1));
  assign w_score_inc = score + 8'd1;
  assign w_levelup   = (w_score_inc != '0) && ((32'(w_score_inc) % LEVEL_BARS) == 32'd0);
  assign w_lives_dec = lives - 2'd1;
  assign w_mv_l      = btn_left & ~btn_right;
  assign w_mv_r      = btn_right & ~btn_left;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_lfsr       <= 16'hACE1;
      r_fcnt       <= '0;
      r_hcnt       <= '0;
      barpos       <= '0;
      holepos      <= 4'd6;
      plrpos       <= 4'd7;
      lives        <= 2'd3;
      cyclesneeded <= 3'd6;
      score        <= '0;
      hit          <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
      hit    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (btn_start) begin
            r_state <= S_PLAY;
            barpos  <= '0;
            holepos <= w_newhole;
            r_fcnt  <= '0;
          end
        end

        S_PLAY: begin
          if (w_mv_l && plrpos != 4'd0)
            plrpos <= plrpos - 4'd1;
          else if (w_mv_r && plrpos != 4'd15)
            plrpos <= plrpos + 4'd1;

          if (frame_tick) begin
            if (w_step) begin
              r_fcnt <= '0;
              if (w_wrap) begin
                barpos  <= '0;
                holepos <= w_newhole;
                score   <= w_score_inc;
                if (w_levelup && cyclesneeded > 3'd2)
                  cyclesneeded <= cyclesneeded - 3'd1;
              end else begin
                barpos <= w_sum[8:0];
                // collision judged with the player column held before this edge's button move
                if (w_cross && w_miss) begin
                  hit    <= 1'b1;
                  lives  <= w_lives_dec;
                  r_hcnt <= '0;
                  if (w_lives_dec == 2'd0) begin
                    r_state   <= S_OVER;
                    game_over <= 1'b1;
                  end else begin
                    r_state <= S_HIT;
                  end
                end
              end
            end else begin
              r_fcnt <= r_fcnt + 3'd1;
            end
          end
        end

        S_HIT: begin
          if (frame_tick) begin
            if (r_hcnt == HIT_LAST) begin
              r_hcnt  <= '0;
              barpos  <= '0;
              holepos <= w_newhole;
              r_fcnt  <= '0;
              r_state <= S_PLAY;
            end else begin
              r_hcnt <= r_hcnt + HW'(1);
            end
          end
        end

        S_OVER: begin
          if (btn_start) begin
            lives        <= 2'd3;
            score        <= '0;
            cyclesneeded <= 3'd6;
            barpos       <= '0;
            holepos      <= w_newhole;
            game_over    <= 1'b0;
            r_fcnt       <= '0;
            r_hcnt       <= '0;
            r_state      <= S_PLAY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector table for player movement, directed
// game sequences, and randomized play compared against a behavioural model.
module tb_game_ctrl;

  localparam int STEP_P  = 8;
  localparam int TOP_P   = 440;
  localparam int EXIT_P  = 509;
  localparam int HITF_P  = 30;
  localparam int LVL_P   = 8;

  logic       dclk, clr, frame_tick, btn_left, btn_right, btn_start;
  logic [8:0] barpos;
  logic [3:0] holepos, plrpos;
  logic [1:0] lives;
  logic [2:0] cyclesneeded;
  logic [7:0] score;
  logic       hit, game_over;

  game_ctrl #(
    .STEP(STEP_P), .PLR_TOP(TOP_P), .BAR_EXIT(EXIT_P),
    .HIT_FRAMES(HITF_P), .LEVEL_BARS(LVL_P)
  ) dut (
    .dclk(dclk), .clr(clr), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .barpos(barpos), .holepos(holepos), .plrpos(plrpos), .lives(lives),
    .cyclesneeded(cyclesneeded), .score(score), .hit(hit), .game_over(game_over)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model: mode 0 waiting, 1 playing, 2 frozen after hit, 3 game over
  int m_mode, m_bar, m_hole, m_plr, m_lives, m_cn, m_score, m_hit, m_go;
  int m_frames, m_hfr, m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_mode = 0; m_bar = 0; m_hole = 6; m_plr = 7; m_lives = 3; m_cn = 6;
    m_score = 0; m_hit = 0; m_go = 0; m_frames = 0; m_hfr = 0; m_lfsr = 'hACE1;
  endtask

  task automatic mdl_clock(input bit st, input bit l, input bit r, input bit tk);
    int hole_next, old_plr, fb;
    bit crossing;
    hole_next = m_lfsr % 16;
    if (hole_next >= 14) hole_next = hole_next - 14;
    old_plr = m_plr;
    m_hit = 0;
    case (m_mode)
      0: if (st) begin m_mode = 1; m_bar = 0; m_hole = hole_next; m_frames = 0; end
      1: begin
        if (l && !r && m_plr > 0) m_plr = m_plr - 1;
        if (r && !l && m_plr < 15) m_plr = m_plr + 1;
        if (tk) begin
          m_frames = m_frames + 1;
          if (m_frames == m_cn) begin
            m_frames = 0;
            if (m_bar + STEP_P >= EXIT_P) begin
              m_bar = 0;
              m_hole = hole_next;
              m_score = (m_score + 1) % 256;
              if (m_score != 0 && m_score % LVL_P == 0 && m_cn > 2) m_cn = m_cn - 1;
            end else begin
              crossing = (m_bar < TOP_P) && (m_bar + STEP_P >= TOP_P);
              m_bar = m_bar + STEP_P;
              if (crossing && (old_plr < m_hole || old_plr > m_hole + 2)) begin
                m_hit = 1;
                m_lives = m_lives - 1;
                m_hfr = 0;
                if (m_lives == 0) begin m_mode = 3; m_go = 1; end
                else m_mode = 2;
              end
            end
          end
        end
      end
      2: if (tk) begin
        m_hfr = m_hfr + 1;
        if (m_hfr == HITF_P) begin
          m_hfr = 0; m_bar = 0; m_hole = hole_next; m_frames = 0; m_mode = 1;
        end
      end
      default: if (st) begin
        m_lives = 3; m_score = 0; m_cn = 6; m_bar = 0; m_hole = hole_next;
        m_go = 0; m_frames = 0; m_hfr = 0; m_mode = 1;
      end
    endcase
    fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
  endtask

  task automatic chk_all();
    check("barpos", int'(barpos), m_bar);
    check("holepos", int'(holepos), m_hole);
    check("plrpos", int'(plrpos), m_plr);
    check("lives", int'(lives), m_lives);
    check("cyclesneeded", int'(cyclesneeded), m_cn);
    check("score", int'(score), m_score);
    check("hit", int'(hit), m_hit);
    check("game_over", int'(game_over), m_go);
  endtask

  // one clock with the given input pulses, then compare everything with the model
  task automatic cyc(input bit st, input bit l, input bit r, input bit tk);
    btn_start = st; btn_left = l; btn_right = r; frame_tick = tk;
    @(posedge dclk);
    mdl_clock(st, l, r, tk);
    #1;
    btn_start = 0; btn_left = 0; btn_right = 0; frame_tick = 0;
    chk_all();
  endtask

  task automatic do_reset();
    clr = 1'b1;
    mdl_reset();
    repeat (2) @(posedge dclk);
    #2;
    clr = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) cyc(0, 0, 0, 1);
  endtask

  task automatic steer(input int target);
    int guard;
    guard = 0;
    while (m_plr != target && guard < 40) begin
      cyc(0, m_plr > target, m_plr < target, 0);
      guard++;
    end
    check("steer_reach", int'(plrpos), target);
  endtask

  function automatic int miss_col(input int h);
    return (h + 3 <= 15) ? h + 3 : h - 1;
  endfunction

  task automatic tick_until_hit();
    int guard;
    guard = 0;
    while (m_hit == 0 && guard < 500) begin
      cyc(0, 0, 0, 1);
      guard++;
    end
    check("hit_seen", int'(hit), 1);
  endtask

  typedef struct {
    bit l;
    bit r;
    int plr;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int saved_plr;
    int guard;
    bit seen8, seen40;

    for (int i = 6; i >= 0; i--) tbl.push_back('{1'b1, 1'b0, i});
    tbl.push_back('{1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 0});
    for (int i = 1; i <= 15; i++) tbl.push_back('{1'b0, 1'b1, i});
    tbl.push_back('{1'b0, 1'b1, 15});
    tbl.push_back('{1'b1, 1'b1, 15});
    tbl.push_back('{1'b1, 1'b0, 14});

    btn_start = 0; btn_left = 0; btn_right = 0; frame_tick = 0; clr = 0;

    // reset state
    do_reset();
    chk_all();
    check("rst_holepos", int'(holepos), 6);
    check("rst_plrpos", int'(plrpos), 7);

    // idle ignores ticks and movement
    for (int i = 0; i < 8; i++) cyc(0, i[0], i[1], 1);
    check("idle_bar", int'(barpos), 0);

    // player movement table
    cyc(1, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(0, tbl[i].l, tbl[i].r, 0);
      check("tbl_plr", int'(plrpos), tbl[i].plr);
    end

    // async clear mid-play
    run_ticks(40);
    #2;
    clr = 1'b1;
    #1;
    check("aclr_bar", int'(barpos), 0);
    check("aclr_hole", int'(holepos), 6);
    check("aclr_plr", int'(plrpos), 7);
    check("aclr_lives", int'(lives), 3);
    check("aclr_cn", int'(cyclesneeded), 6);
    check("aclr_score", int'(score), 0);
    check("aclr_go", int'(game_over), 0);
    mdl_reset();
    @(posedge dclk);
    #2;
    clr = 1'b0;
    run_ticks(12);
    check("aclr_idle_bar", int'(barpos), 0);

    // bar descent and pass through the hole
    do_reset();
    cyc(1, 0, 0, 0);
    steer(m_hole + 1);
    run_ticks(6);
    check("bar_first_step", int'(barpos), 8);
    run_ticks(324);
    check("bar_440", int'(barpos), 440);
    check("pass_no_hit", int'(hit), 0);
    check("pass_lives", int'(lives), 3);
    run_ticks(48);
    check("bar_504", int'(barpos), 504);
    run_ticks(6);
    check("wrap_bar", int'(barpos), 0);
    check("wrap_score", int'(score), 1);
    check("wrap_hole_range", int'(holepos <= 4'd13), 1);

    // collision, freeze, then return to play
    do_reset();
    cyc(1, 0, 0, 0);
    steer(miss_col(m_hole));
    run_ticks(330);
    check("col_hit", int'(hit), 1);
    check("col_lives", int'(lives), 2);
    check("col_bar", int'(barpos), 440);
    cyc(0, 1, 0, 0);
    check("col_hit_pulse", int'(hit), 0);
    run_ticks(29);
    check("freeze_bar", int'(barpos), 440);
    run_ticks(1);
    check("unfreeze_bar", int'(barpos), 0);
    check("unfreeze_score", int'(score), 0);

    // two more collisions end the game
    steer(miss_col(m_hole));
    tick_until_hit();
    check("col2_lives", int'(lives), 1);
    run_ticks(HITF_P);
    steer(miss_col(m_hole));
    tick_until_hit();
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    saved_plr = m_plr;
    for (int i = 0; i < 20; i++) cyc(0, i[0], i[1], 1);
    check("over_bar_frozen", int'(barpos), 440);
    check("over_plr_frozen", int'(plrpos), saved_plr);
    cyc(1, 0, 0, 0);
    check("restart_lives", int'(lives), 3);
    check("restart_score", int'(score), 0);
    check("restart_cn", int'(cyclesneeded), 6);
    check("restart_go", int'(game_over), 0);
    check("restart_bar", int'(barpos), 0);

    // level speed-up with ticks every cycle while steering into each hole
    do_reset();
    cyc(1, 0, 0, 0);
    seen8 = 0; seen40 = 0; guard = 0;
    while (m_score < 48 && guard < 20000) begin
      cyc(0, m_plr > m_hole + 1, m_plr < m_hole + 1, 1);
      if (m_score == 8 && !seen8) begin
        seen8 = 1;
        check("lvl_8_cn", int'(cyclesneeded), 5);
      end
      if (m_score == 40 && !seen40) begin
        seen40 = 1;
        check("lvl_40_cn", int'(cyclesneeded), 2);
      end
      guard++;
    end
    check("lvl_48_score", int'(score), 48);
    check("lvl_48_cn", int'(cyclesneeded), 2);
    check("lvl_lives", int'(lives), 3);

    // randomized play against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
